// File: rtl/one_wire_pkg.sv
// Shared types, constants and helpers for the 1-wire CRC engine.
package one_wire_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [7:0]  POLY_DALLAS8 = 8'h31;
  localparam logic [15:0] POLY_CRC16   = 16'h8005;

  // Reverse the lowest 'width' bits of 'value'; bits above 'width' come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] result;
    result = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        result[i] = value[width-1-i];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/one_wire_crc_lfsr.sv
// One-bit CRC next-state function. Reflected (LSB-first) or normal (MSB-first) form.
module one_wire_crc_lfsr
  import one_wire_pkg::*;
#(
  parameter int                   CRC_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY  = CRC_WIDTH'(POLY_DALLAS8),
  parameter int                   REFLECT   = 1
) (
  input  logic [CRC_WIDTH-1:0] crc,
  input  logic                 data_bit,
  output logic [CRC_WIDTH-1:0] crc_next
);

  localparam logic [CRC_WIDTH-1:0] POLY_REV = CRC_WIDTH'(bitrev(32'(CRC_POLY), CRC_WIDTH));

  logic feedback;

  // Shift the register one bit and fold in the polynomial when the feedback bit is set.
  always_comb begin
    feedback = 1'b0;
    crc_next = crc;
    if (REFLECT != 0) begin
      feedback = crc[0] ^ data_bit;
      crc_next = (crc >> 1) ^ (feedback ? POLY_REV : '0);
    end else begin
      feedback = crc[CRC_WIDTH-1] ^ data_bit;
      crc_next = (crc << 1) ^ (feedback ? CRC_POLY : '0);
    end
  end

endmodule

// File: rtl/one_wire_crc_engine.sv
// Bit-serial CRC generator/checker with a valid/ready bit interface and frame-length counter.
module one_wire_crc_engine
  import one_wire_pkg::*;
#(
  parameter int                   CRC_WIDTH     = 8,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY      = CRC_WIDTH'(POLY_DALLAS8),
  parameter logic [CRC_WIDTH-1:0] CRC_INIT      = '0,
  parameter int                   REFLECT       = 1,
  parameter int                   DATA_BITS     = 56,
  parameter logic [CRC_WIDTH-1:0] CHECK_RESIDUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 check_mode,
  input  logic                 abort,
  input  logic                 bit_valid,
  input  logic                 bit_data,
  output logic                 bit_ready,
  output logic                 busy,
  output logic [CRC_WIDTH-1:0] crc_data,
  output logic                 crc_valid,
  output logic                 crc_match
);

  localparam int CNT_W = $clog2(DATA_BITS + CRC_WIDTH + 1);
  localparam logic [CNT_W-1:0] LEN_PLAIN = CNT_W'(DATA_BITS);
  localparam logic [CNT_W-1:0] LEN_CHECK = CNT_W'(DATA_BITS + CRC_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     bit_count;
  logic [CRC_WIDTH-1:0] crc_reg;
  logic [CRC_WIDTH-1:0] crc_next;
  logic                 match_reg;
  logic                 load;
  logic                 accept;
  logic                 done_pulse;

  one_wire_crc_lfsr #(
    .CRC_WIDTH(CRC_WIDTH),
    .CRC_POLY (CRC_POLY),
    .REFLECT  (REFLECT)
  ) u_lfsr (
    .crc     (crc_reg),
    .data_bit(bit_data),
    .crc_next(crc_next)
  );

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-cycle strobes; abort overrides start, and start in SHIFT/DONE restarts the frame.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    accept     = 1'b0;
    done_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (start) begin
          load = 1'b1;
        end else if (bit_valid) begin
          accept = 1'b1;
          if (bit_count == CNT_ONE) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end else begin
          done_pulse = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      load       = 1'b0;
      accept     = 1'b0;
      done_pulse = 1'b0;
    end
  end

  // CRC register, remaining-bit counter and match flag; the match is captured with the last bit so it is valid alongside crc_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_reg   <= CRC_INIT;
      bit_count <= '0;
      match_reg <= 1'b0;
    end else if (abort) begin
      match_reg <= 1'b0;
    end else if (load) begin
      crc_reg   <= CRC_INIT;
      bit_count <= check_mode ? LEN_CHECK : LEN_PLAIN;
      match_reg <= 1'b0;
    end else if (accept) begin
      crc_reg   <= crc_next;
      bit_count <= bit_count - CNT_ONE;
      if (bit_count == CNT_ONE) begin
        match_reg <= (crc_next == CHECK_RESIDUE);
      end
    end
  end

  assign bit_ready = (state == SHIFT);
  assign busy      = (state != IDLE);
  assign crc_data  = crc_reg;
  assign crc_valid = done_pulse & ~rst;
  assign crc_match = match_reg;

endmodule

// File: tb/tb_one_wire_crc_engine.sv
// Directed self-checking bench for one_wire_crc_engine across three parameter sets.
module tb_one_wire_crc_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic check_mode = 1'b0;
  logic abort = 1'b0;
  logic bit_valid = 1'b0;
  logic bit_data = 1'b0;

  logic        bit_ready_a, busy_a, crc_valid_a, crc_match_a;
  logic [7:0]  crc_a;
  logic        bit_ready_b, busy_b, crc_valid_b, crc_match_b;
  logic [7:0]  crc_b;
  logic        bit_ready_c, busy_c, crc_valid_c, crc_match_c;
  logic [15:0] crc_c;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  int pulses_c = 0;

  always #5 clk = ~clk;

  // Dallas CRC-8, default parameters
  one_wire_crc_engine dut_a (
    .clk(clk), .rst(rst), .start(start), .check_mode(check_mode), .abort(abort),
    .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready_a), .busy(busy_a),
    .crc_data(crc_a), .crc_valid(crc_valid_a), .crc_match(crc_match_a)
  );

  // CRC-8 poly 0x07, MSB-first, 9-byte frame
  one_wire_crc_engine #(
    .CRC_WIDTH(8), .CRC_POLY(8'h07), .REFLECT(0), .DATA_BITS(72)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .check_mode(check_mode), .abort(abort),
    .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready_b), .busy(busy_b),
    .crc_data(crc_b), .crc_valid(crc_valid_b), .crc_match(crc_match_b)
  );

  // CRC-16 poly 0x8005 reflected, one byte
  one_wire_crc_engine #(
    .CRC_WIDTH(16), .CRC_POLY(16'h8005), .REFLECT(1), .DATA_BITS(8)
  ) dut_c (
    .clk(clk), .rst(rst), .start(start), .check_mode(check_mode), .abort(abort),
    .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready_c), .busy(busy_c),
    .crc_data(crc_c), .crc_valid(crc_valid_c), .crc_match(crc_match_c)
  );

  // Count crc_valid pulses per instance, sampled mid-cycle
  always @(negedge clk) begin
    if (crc_valid_a) pulses_a++;
    if (crc_valid_b) pulses_b++;
    if (crc_valid_c) pulses_c++;
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    string        name;
    int           dut;
    bit           cm;
    int           nbits;
    logic [127:0] bits;
    bit           gaps;
    bit           check_crc;
    logic [31:0]  exp_crc;
    bit           exp_match;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t make_vec(input string name, input int dut, input bit cm, input int nbits,
                                    input logic [127:0] bits, input bit gaps, input bit check_crc,
                                    input logic [31:0] exp_crc, input bit exp_match);
    vec_t v;
    v.name = name; v.dut = dut; v.cm = cm; v.nbits = nbits; v.bits = bits;
    v.gaps = gaps; v.check_crc = check_crc; v.exp_crc = exp_crc; v.exp_match = exp_match;
    return v;
  endfunction

  // Bytes packed little-endian (byte 0 in bits 7:0) turned into an MSB-first bit stream
  function automatic logic [127:0] msb_stream(input logic [127:0] le, input int nbytes);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < nbytes; k++) begin
      for (int j = 0; j < 8; j++) begin
        r[8*k+j] = le[8*k+7-j];
      end
    end
    return r;
  endfunction

  // Reference bitwise CRC for the first n stream bits of the given instance's parameter set
  function automatic logic [31:0] crc_model(input int dut, input logic [127:0] bits, input int n);
    int          w;
    logic [31:0] poly, rpoly, mask, c;
    bit          refl;
    logic        fb;
    case (dut)
      1:       begin w = 8;  poly = 32'h07;   refl = 1'b0; end
      2:       begin w = 16; poly = 32'h8005; refl = 1'b1; end
      default: begin w = 8;  poly = 32'h31;   refl = 1'b1; end
    endcase
    mask  = (32'h1 << w) - 32'h1;
    rpoly = '0;
    for (int k = 0; k < w; k++) rpoly[k] = poly[w-1-k];
    c = '0;
    for (int i = 0; i < n; i++) begin
      if (refl) begin
        fb = c[0] ^ bits[i];
        c  = c >> 1;
        if (fb) c = c ^ rpoly;
      end else begin
        fb = c[w-1] ^ bits[i];
        c  = (c << 1) & mask;
        if (fb) c = c ^ poly;
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] crc_sel(input int dut);
    case (dut)
      1:       return 32'(crc_b);
      2:       return 32'(crc_c);
      default: return 32'(crc_a);
    endcase
  endfunction

  function automatic logic [31:0] flags_sel(input int dut);
    // {busy, bit_ready, crc_valid, crc_match}
    case (dut)
      1:       return {28'd0, busy_b, bit_ready_b, crc_valid_b, crc_match_b};
      2:       return {28'd0, busy_c, bit_ready_c, crc_valid_c, crc_match_c};
      default: return {28'd0, busy_a, bit_ready_a, crc_valid_a, crc_match_a};
    endcase
  endfunction

  function automatic int pulses_sel(input int dut);
    case (dut)
      1:       return pulses_b;
      2:       return pulses_c;
      default: return pulses_a;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame(input bit cm);
    start      = 1'b1;
    check_mode = cm;
    bit_valid  = 1'b0;
    cyc        = 1;
    next_cycle();
    start = 1'b0;
    cyc   = 2;
  endtask

  // Present n bits, optionally with random idle cycles; idle cycles must leave the CRC untouched
  task automatic stream_bits(input logic [127:0] bits, input int n, input bit gaps, input int dut);
    int i;
    int iter;
    i    = 0;
    iter = 0;
    while (i < n && iter < 8 * n + 16) begin
      iter++;
      if (gaps && $urandom_range(0, 1) == 0) begin
        bit_valid = 1'b0;
        bit_data  = ~bits[i];
        next_cycle();
        cyc++;
        checkOutput("gap_hold", crc_sel(dut), crc_model(dut, bits, i));
      end else begin
        bit_valid = 1'b1;
        bit_data  = bits[i];
        next_cycle();
        cyc++;
        i++;
      end
    end
    bit_valid = 1'b0;
    if (i < n) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL stream_budget: got %0d bits, expected %0d", i, n);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int base;
    logic [31:0] fl;
    base = pulses_sel(v.dut);
    begin_frame(v.cm);
    stream_bits(v.bits, v.nbits, v.gaps, v.dut);
    @(negedge clk);
    fl = flags_sel(v.dut);
    checkOutput({v.name, ":valid"}, 32'(fl[1]), 32'd1);
    checkOutput({v.name, ":busy_done"}, 32'(fl[3]), 32'd1);
    if (!v.gaps) checkOutput({v.name, ":latency"}, 32'(cyc), 32'(v.nbits + 2));
    if (v.check_crc) checkOutput({v.name, ":crc"}, crc_sel(v.dut), v.exp_crc);
    checkOutput({v.name, ":match"}, 32'(fl[0]), 32'(v.exp_match));
    next_cycle();
    fl = flags_sel(v.dut);
    checkOutput({v.name, ":valid_after"}, 32'(fl[1]), 32'd0);
    checkOutput({v.name, ":busy_after"}, 32'(fl[3]), 32'd0);
    checkOutput({v.name, ":match_held"}, 32'(fl[0]), 32'(v.exp_match));
    checkOutput({v.name, ":pulses"}, 32'(pulses_sel(v.dut) - base), 32'd1);
  endtask

  logic [127:0] rom_bits;
  logic [127:0] chk_bits;
  logic [127:0] bad_bits;
  logic [127:0] ascii_bits;
  int           base_a;

  initial begin
    rom_bits   = 128'h00000001B81C02;
    chk_bits   = 128'hA200000001B81C02;
    bad_bits   = chk_bits ^ 128'h400;
    ascii_bits = msb_stream(128'h393837363534333231, 9);

    vecs[0] = make_vec("dallas_gen",   0, 1'b0, 56, rom_bits,     1'b0, 1'b1, 32'hA2,   1'b0);
    vecs[1] = make_vec("dallas_chk",   0, 1'b1, 64, chk_bits,     1'b0, 1'b1, 32'h00,   1'b1);
    vecs[2] = make_vec("dallas_bad",   0, 1'b1, 64, bad_bits,     1'b0, 1'b0, 32'h00,   1'b0);
    vecs[3] = make_vec("crc8_msb",     1, 1'b0, 72, ascii_bits,   1'b0, 1'b1, 32'hF4,   1'b0);
    vecs[4] = make_vec("crc16_byte",   2, 1'b0, 8,  128'h01,      1'b0, 1'b1, 32'hC0C1, 1'b0);
    vecs[5] = make_vec("dallas_gaps",  0, 1'b0, 56, rom_bits,     1'b1, 1'b1, 32'hA2,   1'b0);

    // Reset state
    repeat (3) next_cycle();
    checkOutput("rst_crc", 32'(crc_a), 32'h00);
    checkOutput("rst_flags", flags_sel(0), 32'h0);
    checkOutput("rst_crc16", 32'(crc_c), 32'h0000);
    rst = 1'b0;
    next_cycle();

    for (int k = 0; k < 6; k++) begin
      applyStimulus(vecs[k]);
      next_cycle();
    end

    // Bits offered while idle are ignored
    base_a    = pulses_a;
    bit_valid = 1'b1;
    bit_data  = 1'b1;
    repeat (4) begin
      next_cycle();
      checkOutput("idle_crc_hold", 32'(crc_a), 32'hA2);
      checkOutput("idle_ready", 32'(bit_ready_a), 32'd0);
    end
    bit_valid = 1'b0;
    checkOutput("idle_no_pulse", 32'(pulses_a - base_a), 32'd0);

    // Abort after 20 bits, with a simultaneous start that must lose
    base_a = pulses_a;
    begin_frame(1'b0);
    stream_bits(rom_bits, 20, 1'b0, 0);
    checkOutput("shift_flags", flags_sel(0), 32'hC);
    abort     = 1'b1;
    start     = 1'b1;
    bit_valid = 1'b1;
    bit_data  = 1'b1;
    next_cycle();
    abort     = 1'b0;
    start     = 1'b0;
    bit_valid = 1'b0;
    checkOutput("abort_flags", flags_sel(0), 32'h0);
    checkOutput("abort_crc", 32'(crc_a), crc_model(0, rom_bits, 20));
    repeat (60) next_cycle();
    checkOutput("abort_no_pulse", 32'(pulses_a - base_a), 32'd0);

    // Restart after 30 bits: reload, ignore the bit in the start cycle, single pulse at end
    base_a = pulses_a;
    begin_frame(1'b0);
    stream_bits(rom_bits, 30, 1'b0, 0);
    checkOutput("pre_restart_crc", 32'(crc_a), crc_model(0, rom_bits, 30));
    start     = 1'b1;
    bit_valid = 1'b1;
    bit_data  = 1'b1;
    next_cycle();
    start     = 1'b0;
    bit_valid = 1'b0;
    cyc       = 2;
    checkOutput("restart_crc_init", 32'(crc_a), 32'h00);
    checkOutput("restart_busy", 32'(busy_a), 32'd1);
    stream_bits(rom_bits, 56, 1'b0, 0);
    @(negedge clk);
    checkOutput("restart_valid", 32'(crc_valid_a), 32'd1);
    checkOutput("restart_crc", 32'(crc_a), 32'hA2);
    next_cycle();
    checkOutput("restart_pulses", 32'(pulses_a - base_a), 32'd1);

    // Reset in the middle of a frame
    begin_frame(1'b0);
    stream_bits(rom_bits, 10, 1'b0, 0);
    rst       = 1'b1;
    bit_valid = 1'b1;
    next_cycle();
    rst       = 1'b0;
    bit_valid = 1'b0;
    checkOutput("midrst_crc", 32'(crc_a), 32'h00);
    checkOutput("midrst_flags", flags_sel(0), 32'h0);
    next_cycle();
    checkOutput("midrst_stays_idle", 32'(busy_a), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/one_wire_crc_engine.md
Name: one_wire_crc_engine

Overview:
Parametrised bit-serial CRC generator/checker for the 1-wire master datapath. It replaces the fixed CRC-8 calculator and supports configurable CRC width, polynomial, init value, bit order and frame length. Bits are accepted through a valid/ready handshake. A check mode verifies a received frame plus appended CRC against a residue. It sits between the 1-wire bit-level transceiver and the ROM/scratchpad command sequencer.

Parameters:
CRC_WIDTH, 8, CRC register width (legal 4..32)
CRC_POLY, 8'h31, normal-form polynomial without the implicit x^CRC_WIDTH term (Dallas CRC-8 = 0x31; CRC-16 = 0x8005)
CRC_INIT, 0, register value loaded on start
REFLECT, 1, 1 = LSB-first (right-shifting, reflected poly); 0 = MSB-first (left-shifting)
DATA_BITS, 56, payload bits per frame (legal 1..1024)
CHECK_RESIDUE, 0, value of crc_data that asserts crc_match
CNT_W, $clog2(DATA_BITS+CRC_WIDTH+1), frame bit counter width (derived, not overridden)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: begin a new frame
check_mode  in  1  sampled on start: 1 = frame is DATA_BITS payload + CRC_WIDTH CRC bits
abort  in  1  one-cycle pulse: discard the frame, return to IDLE
bit_valid  in  1  bit_data holds a bit
bit_data  in  1  serial data bit
bit_ready  out  1  engine accepts a bit this cycle
busy  out  1  frame in progress
crc_data  out  CRC_WIDTH  CRC register contents
crc_valid  out  1  one-cycle pulse: frame complete, result final
crc_match  out  1  crc_data == CHECK_RESIDUE; qualified by crc_valid, then held

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; crc_data=CRC_INIT; crc_valid=0; crc_match=0; bit_ready=0; busy=0; counter=0; mode register=0. rst overrides every other input.
- States:
  - IDLE: bit_ready=0, busy=0. On start: crc<=CRC_INIT; counter<=DATA_BITS (+CRC_WIDTH if check_mode); latch check_mode; crc_match<=0; go to SHIFT.
  - SHIFT: bit_ready=1, busy=1. A bit is accepted when bit_valid && bit_ready. Each accepted bit updates crc and decrements counter. When the accepted bit has counter==1, go to DONE.
  - DONE: one cycle. crc_valid=1; crc_match<=(crc==CHECK_RESIDUE); go to IDLE. busy=1 in DONE.
- CRC update per accepted bit b:
  - REFLECT=1: fb=crc[0]^b; crc=(crc>>1)^(fb ? bitrev(CRC_POLY) : 0).
  - REFLECT=0: fb=crc[W-1]^b; crc=(crc<<1)^(fb ? CRC_POLY : 0).
  - No final XOR and no output reflection. Check mode feeds the CRC bits through the same update, so the residue is 0 for a correct frame.
- Latency: crc_valid asserts exactly 1 cycle after the last bit is accepted. With bit_valid held high, a frame takes N+2 cycles from start (1 load cycle, N shift cycles, 1 DONE cycle).
- bit_valid while not in SHIFT is ignored (no update).
- crc_data and crc_match hold after DONE until the next start or rst.
- start in SHIFT or DONE restarts the frame: reload as in IDLE, suppress crc_valid, and ignore any bit presented that cycle.
- abort in any state: go to IDLE, crc_valid=0, crc_match=0, crc_data retains its value. abort takes priority over a simultaneous start.
- crc_valid is never asserted for an aborted or restarted frame.

Decomposition:
- Package one_wire_pkg: state enum (IDLE, SHIFT, DONE), Dallas constants (POLY_DALLAS8=8'h31, POLY_CRC16=16'h8005), and a bitrev function.
- Sub-module one_wire_crc_lfsr: combinational next-state function, parametrised by CRC_WIDTH/CRC_POLY/REFLECT; inputs crc and bit, output crc_next. The FSM, counter and handshake stay in the top module.

Test Plan:
- Default params, check_mode=0; stream ROM bytes 02 1C B8 01 00 00 00 LSB-first with bit_valid held high -> crc_valid pulses at cycle 58 after start, crc_data=8'hA2.
- Same frame, check_mode=1, appended byte A2 LSB-first -> crc_data=0, crc_match=1; repeat with one payload bit flipped -> crc_match=0.
- REFLECT=0, CRC_POLY=8'h07, DATA_BITS=72; ASCII "123456789" MSB-first -> crc_data=8'hF4.
- Random bit_valid gaps (~50% duty) on the first scenario -> same 8'hA2; crc is unchanged on cycles with bit_valid=0; bit_valid outside SHIFT has no effect.
- abort after 20 bits -> IDLE next cycle, no crc_valid; start during SHIFT after 30 bits -> crc reloads to CRC_INIT, full frame recomputed, single crc_valid at end.
- rst asserted mid-frame -> next cycle crc_data=CRC_INIT, busy=0, bit_ready=0, crc_valid=0; CRC_WIDTH=16, CRC_POLY=16'h8005, REFLECT=1, DATA_BITS=8, byte 0x01 -> crc_data=16'hC0C1.
